// File: rtl/video_gray2rgb_core_pkg.sv
// Shared types and register map for the gray-to-RGB pseudo-colour core.
package video_gray2rgb_core_pkg;

  localparam int unsigned AVS_AW = 2;
  localparam int unsigned AVS_DW = 32;

  localparam logic [AVS_AW-1:0] REG_CTRL     = AVS_AW'(0);
  localparam logic [AVS_AW-1:0] REG_PAL_IDX  = AVS_AW'(1);
  localparam logic [AVS_AW-1:0] REG_PAL_DATA = AVS_AW'(2);

  // Frame control travelling alongside every pixel of the video stream.
  typedef struct packed {
    logic sof;
    logic eof;
    logic sol;
    logic eol;
  } vga_fc_t;

endpackage

// File: rtl/video_gray2rgb_core_palette_ram.sv
// Palette storage: 1 write port, 1 synchronous read port with enable, read-before-write.
module video_palette_ram #(
  parameter int unsigned DW = 12,
  parameter int unsigned AW = 4
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic          re,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rdata
);

  localparam int unsigned DEPTH = 1 << AW;

  logic [DW-1:0] mem_q [DEPTH];

  // Both updates are non-blocking, so a same-address read sees the old word.
  always_ff @(posedge clk) begin
    if (we) mem_q[waddr] <= wdata;
    if (re) rdata <= mem_q[raddr];
  end

endmodule

// File: rtl/video_gray2rgb_core.sv
// Pseudo-colour core: maps gray pixels to RGB through an Avalon-programmed palette.
module video_gray2rgb_core
  import video_gray2rgb_core_pkg::*;
#(
  parameter int unsigned RSIZE    = 4,
  parameter int unsigned GSIZE    = 4,
  parameter int unsigned BSIZE    = 4,
  parameter int unsigned RGB_SIZE = RSIZE + GSIZE + BSIZE,
  parameter int unsigned LUT_AW   = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                avs_write,
  input  logic [AVS_AW-1:0]   avs_address,
  input  logic [AVS_DW-1:0]   avs_writedata,
  input  logic                src_vld,
  output logic                src_rdy,
  input  vga_fc_t             src_fc,
  input  logic [RGB_SIZE-1:0] src_rgb,
  input  logic                snk_rdy,
  output logic                snk_vld,
  output vga_fc_t             snk_fc,
  output logic [RGB_SIZE-1:0] snk_rgb
);

  logic                bypass_q,  bypass_d;
  logic [LUT_AW-1:0]   pal_idx_q, pal_idx_d;

  logic                s1_vld_q, s1_vld_d;
  vga_fc_t             s1_fc_q,  s1_fc_d;
  logic [RGB_SIZE-1:0] s1_rgb_q, s1_rgb_d;
  logic [LUT_AW-1:0]   s1_idx_q, s1_idx_d;
  logic                s1_byp_q, s1_byp_d;

  logic                s2_vld_q, s2_vld_d;
  vga_fc_t             s2_fc_q,  s2_fc_d;
  logic [RGB_SIZE-1:0] s2_rgb_q, s2_rgb_d;
  logic                s2_byp_q, s2_byp_d;

  logic                adv1_c, adv2_c;
  logic                pal_we_c;
  logic [RGB_SIZE-1:0] pal_rdata;
  logic                unused_wdata_c;

  assign unused_wdata_c = ^avs_writedata[AVS_DW-1:RGB_SIZE];

  // Register file, handshake and pipeline next-state.
  always_comb begin
    bypass_d  = bypass_q;
    pal_idx_d = pal_idx_q;
    s1_vld_d  = s1_vld_q;
    s1_fc_d   = s1_fc_q;
    s1_rgb_d  = s1_rgb_q;
    s1_idx_d  = s1_idx_q;
    s1_byp_d  = s1_byp_q;
    s2_vld_d  = s2_vld_q;
    s2_fc_d   = s2_fc_q;
    s2_rgb_d  = s2_rgb_q;
    s2_byp_d  = s2_byp_q;

    adv2_c   = !s2_vld_q || snk_rdy;
    adv1_c   = !s1_vld_q || adv2_c;
    pal_we_c = avs_write && (avs_address == REG_PAL_DATA);

    if (avs_write) begin
      case (avs_address)
        REG_CTRL:     bypass_d  = avs_writedata[0];
        REG_PAL_IDX:  pal_idx_d = avs_writedata[LUT_AW-1:0];
        REG_PAL_DATA: pal_idx_d = pal_idx_q + LUT_AW'(1);
        default:      ;
      endcase
    end

    // Bypass is latched with the pixel so ctrl writes never touch pixels in flight.
    if (adv1_c) begin
      s1_vld_d = src_vld;
      s1_fc_d  = src_fc;
      s1_rgb_d = src_rgb;
      s1_idx_d = src_rgb[BSIZE+GSIZE-1 -: LUT_AW];
      s1_byp_d = bypass_q;
    end

    if (adv2_c) begin
      s2_vld_d = s1_vld_q;
      s2_fc_d  = s1_fc_q;
      s2_rgb_d = s1_rgb_q;
      s2_byp_d = s1_byp_q;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bypass_q  <= 1'b1;
      pal_idx_q <= '0;
      s1_vld_q  <= 1'b0;
      s1_fc_q   <= '0;
      s1_rgb_q  <= '0;
      s1_idx_q  <= '0;
      s1_byp_q  <= 1'b1;
      s2_vld_q  <= 1'b0;
      s2_fc_q   <= '0;
      s2_rgb_q  <= '0;
      s2_byp_q  <= 1'b1;
    end else begin
      bypass_q  <= bypass_d;
      pal_idx_q <= pal_idx_d;
      s1_vld_q  <= s1_vld_d;
      s1_fc_q   <= s1_fc_d;
      s1_rgb_q  <= s1_rgb_d;
      s1_idx_q  <= s1_idx_d;
      s1_byp_q  <= s1_byp_d;
      s2_vld_q  <= s2_vld_d;
      s2_fc_q   <= s2_fc_d;
      s2_rgb_q  <= s2_rgb_d;
      s2_byp_q  <= s2_byp_d;
    end
  end

  // Read enable follows stage-2 advance so a stalled output keeps its colour.
  video_palette_ram #(
    .DW (RGB_SIZE),
    .AW (LUT_AW)
  ) u_palette (
    .clk   (clk),
    .we    (pal_we_c),
    .waddr (pal_idx_q),
    .wdata (avs_writedata[RGB_SIZE-1:0]),
    .re    (adv2_c),
    .raddr (s1_idx_q),
    .rdata (pal_rdata)
  );

  assign src_rdy = adv1_c;
  assign snk_vld = s2_vld_q;
  assign snk_fc  = s2_fc_q;
  assign snk_rgb = s2_byp_q ? s2_rgb_q : pal_rdata;

endmodule

// File: tb/tb_video_gray2rgb_core.sv
// Self-checking bench for video_gray2rgb_core: directed steps plus a random stream vs. a reference model.
module tb_video_gray2rgb_core;
  import video_gray2rgb_core_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        avs_write;
  logic [1:0]  avs_address;
  logic [31:0] avs_writedata;
  logic        src_vld;
  logic        src_rdy;
  vga_fc_t     src_fc;
  logic [11:0] src_rgb;
  logic        snk_rdy;
  logic        snk_vld;
  vga_fc_t     snk_fc;
  logic [11:0] snk_rgb;

  video_gray2rgb_core dut (
    .clk           (clk),
    .rst           (rst),
    .avs_write     (avs_write),
    .avs_address   (avs_address),
    .avs_writedata (avs_writedata),
    .src_vld       (src_vld),
    .src_rdy       (src_rdy),
    .src_fc        (src_fc),
    .src_rgb       (src_rgb),
    .snk_rdy       (snk_rdy),
    .snk_vld       (snk_vld),
    .snk_fc        (snk_fc),
    .snk_rgb       (snk_rgb)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Reference model: register file and palette contents, plus expected {fc, rgb} queue.
  bit          mbyp;
  bit [3:0]    midx;
  bit [11:0]   mpal [16];
  logic [15:0] expq [$];

  // Values seen on the DUT in the most recent cycle, just before its active edge.
  bit          o_src_rdy;
  bit          o_vld;
  logic [11:0] o_rgb;

  function automatic logic [11:0] exp_px(input logic [11:0] rgb);
    logic [3:0] gray;
    gray = rgb[7:4];
    return mbyp ? rgb : mpal[gray];
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock cycle: drive, check any output handshake, record any input handshake, update model.
  task automatic cycle(input bit v, input logic [11:0] rgb, input logic [3:0] fc, input bit rdy,
                       input bit aw, input logic [1:0] aa, input logic [31:0] ad, output bit acc);
    logic [15:0] e;
    src_vld = v; src_rgb = rgb; src_fc = vga_fc_t'(fc); snk_rdy = rdy;
    avs_write = aw; avs_address = aa; avs_writedata = ad;
    #1;
    o_src_rdy = src_rdy; o_vld = snk_vld; o_rgb = snk_rgb;
    if (snk_vld && snk_rdy) begin
      total++;
      assert (expq.size() > 0) else begin
        bad++;
        $error("FAIL spurious_out observed=%0h expected=no_output", snk_rgb);
      end
      if (expq.size() > 0) begin
        e = expq.pop_front();
        chk("out_rgb", 32'(snk_rgb), 32'(e[11:0]));
        chk("out_fc", 32'(snk_fc), 32'(e[15:12]));
      end
    end
    acc = v && src_rdy;
    if (acc) expq.push_back({fc, exp_px(rgb)});
    @(posedge clk);
    if (aw) begin
      case (aa)
        2'd0: mbyp = ad[0];
        2'd1: midx = ad[3:0];
        2'd2: begin mpal[midx] = ad[11:0]; midx = midx + 4'd1; end
        default: ;
      endcase
    end
    @(negedge clk);
    avs_write = 1'b0;
  endtask

  task automatic idle(input bit rdy);
    bit acc;
    cycle(1'b0, 12'h000, 4'h0, rdy, 1'b0, 2'd0, 32'd0, acc);
  endtask

  task automatic avs(input logic [1:0] a, input logic [31:0] d);
    bit acc;
    cycle(1'b0, 12'h000, 4'h0, 1'b1, 1'b1, a, d, acc);
  endtask

  task automatic send(input logic [11:0] rgb, input logic [3:0] fc);
    bit acc;
    cycle(1'b1, rgb, fc, 1'b1, 1'b0, 2'd0, 32'd0, acc);
    chk("send_accept", 32'(acc), 32'd1);
  endtask

  task automatic flush(input string tag);
    for (int i = 0; i < 12 && expq.size() != 0; i++) idle(1'b1);
    chk(tag, 32'(expq.size()), 32'd0);
  endtask

  bit          acc;
  bit          v, rdy, aw;
  logic [11:0] px, held;
  logic [3:0]  pfc;
  int          naccept;

  initial begin
    rst = 1'b0; avs_write = 1'b0; avs_address = '0; avs_writedata = '0;
    src_vld = 1'b0; src_fc = '0; src_rgb = '0; snk_rdy = 1'b0;
    mbyp = 1'b1; midx = 4'd0;
    repeat (2) @(negedge clk);
    chk("rst_snk_vld", 32'(snk_vld), 32'd0);
    chk("rst_src_rdy", 32'(src_rdy), 32'd1);
    chk("rst_snk_rgb", 32'(snk_rgb), 32'd0);
    chk("rst_snk_fc", 32'(snk_fc), 32'd0);
    rst = 1'b1;
    @(negedge clk);

    // Bypass after reset and two-cycle latency.
    cycle(1'b1, 12'hABC, 4'h9, 1'b1, 1'b0, 2'd0, 32'd0, acc);
    chk("first_accept", 32'(acc), 32'd1);
    idle(1'b1);
    chk("lat1_vld", 32'(o_vld), 32'd0);
    idle(1'b1);
    chk("lat2_vld", 32'(o_vld), 32'd1);
    chk("lat2_rgb", 32'(o_rgb), 32'hABC);
    flush("drain_bypass");

    // Program palette k*0x111 ^ 0xF00, then enable colour mapping.
    avs(REG_PAL_IDX, 32'd0);
    for (int k = 0; k < 16; k++) avs(REG_PAL_DATA, 32'((k * 12'h111) ^ 12'hF00));
    avs(REG_CTRL, 32'd0);
    send(12'h333, 4'h1);
    for (int i = 0; i < 2; i++) idle(1'b1);
    chk("pal3_vld", 32'(o_vld), 32'd1);
    chk("pal3_rgb", 32'(o_rgb), 32'hC33);
    flush("drain_pal");

    // Stall: continuous input, downstream not ready for 5 cycles.
    px = 12'h5C2; pfc = 4'h2; naccept = 0; held = 12'h000;
    for (int i = 0; i < 14; i++) begin
      cycle(1'b1, px, pfc, (i >= 5), 1'b0, 2'd0, 32'd0, acc);
      if (i < 5 && acc) naccept++;
      if (i == 2) held = o_rgb;
      if (i >= 2 && i < 5) begin
        chk("stall_src_rdy", 32'(o_src_rdy), 32'd0);
        chk("stall_vld", 32'(o_vld), 32'd1);
        chk("stall_hold", 32'(o_rgb), 32'(held));
      end
      if (acc) begin px = px + 12'h131; pfc = pfc + 4'd3; end
    end
    chk("stall_accepts", 32'(naccept), 32'd2);
    flush("drain_stall");

    // Palette write to the entry being read in the same cycle returns the old colour.
    avs(REG_PAL_IDX, 32'd3);
    send(12'h333, 4'h4);
    avs(REG_PAL_DATA, 32'h0F0);
    send(12'h333, 4'h8);
    flush("drain_rbw");

    // Index wrap 15 -> 0.
    avs(REG_PAL_IDX, 32'd15);
    avs(REG_PAL_DATA, 32'h1E5);
    avs(REG_PAL_DATA, 32'h2D6);
    send(12'hFFF, 4'h0);
    send(12'h000, 4'h0);
    flush("drain_wrap");

    // Asynchronous reset with a pixel on the output.
    for (int i = 0; i < 6 && !o_vld; i++)
      cycle(1'b1, 12'h777, 4'h3, 1'b1, 1'b0, 2'd0, 32'd0, acc);
    chk("pre_rst_vld", 32'(o_vld), 32'd1);
    #2 rst = 1'b0;
    #1;
    chk("async_rst_vld", 32'(snk_vld), 32'd0);
    chk("async_rst_rdy", 32'(src_rdy), 32'd1);
    chk("async_rst_rgb", 32'(snk_rgb), 32'd0);
    chk("async_rst_fc", 32'(snk_fc), 32'd0);
    expq.delete();
    mbyp = 1'b1; midx = 4'd0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    send(12'h5A7, 4'h5);
    flush("drain_post_rst_bypass");
    avs(REG_PAL_DATA, 32'h9E1);
    avs(REG_CTRL, 32'd0);
    send(12'h505, 4'h6);
    send(12'h777, 4'h7);
    flush("drain_post_rst_idx");

    // Random stream with random backpressure and mid-stream bypass toggling.
    px = 12'($urandom); pfc = 4'($urandom);
    for (int i = 0; i < 400; i++) begin
      v   = ($urandom_range(9) < 7);
      rdy = ($urandom_range(9) < 6);
      aw  = ($urandom_range(15) == 0);
      cycle(v, px, pfc, rdy, aw, REG_CTRL, 32'($urandom_range(1)), acc);
      if (acc) begin px = 12'($urandom); pfc = 4'($urandom); end
    end
    flush("drain_random");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
